// File: rtl/mmt_sync_edge_filter.sv
// Debounce stage behind a single-bit synchroniser: filtered level, edge pulses, event count.
// Flip lands FILT_CYCLES-1 edges after the first differing sample; no backpressure (always accepts).
module mmt_sync_edge_filter #(
   parameter int   FILT_CYCLES = 4,
   parameter int   CNT_W       = 8,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             sync_in,
   input  logic             cnt_clr,
   output logic             filt_q,
   output logic             rise_pls,
   output logic             fall_pls,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             busy
);

   localparam int SW = $clog2(FILT_CYCLES + 1);

   typedef enum logic {STABLE = 1'b0, QUAL = 1'b1} state_t;

   state_t        state;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] cnt_inc;
   logic          diff;
   logic          flip;

   always_comb begin
      diff    = en && (sync_in != filt_q);
      cnt_inc = stab_cnt + SW'(1);
      flip    = 1'b0;
      if (state == STABLE)
         flip = diff && (FILT_CYCLES == 1);
      else
         flip = diff && (cnt_inc == SW'(FILT_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= STABLE;
         stab_cnt <= '0;
         filt_q   <= RST_VAL;
         rise_pls <= 1'b0;
         fall_pls <= 1'b0;
         evt_cnt  <= '0;
      end else begin
         rise_pls <= flip & ~filt_q;
         fall_pls <= flip &  filt_q;
         if (flip)
            filt_q <= ~filt_q;

         // A clear coinciding with a flip still counts that flip.
         if (cnt_clr)
            evt_cnt <= flip ? CNT_W'(1) : '0;
         else if (flip && !(&evt_cnt))
            evt_cnt <= evt_cnt + CNT_W'(1);

         case (state)
            STABLE: begin
               if (diff) begin
                  if (FILT_CYCLES == 1) begin
                     stab_cnt <= '0;
                  end else begin
                     stab_cnt <= SW'(1);
                     state    <= QUAL;
                  end
               end
            end
            QUAL: begin
               if (!diff || flip) begin
                  state    <= STABLE;
                  stab_cnt <= '0;
               end else begin
                  stab_cnt <= cnt_inc;
               end
            end
            default: begin
               state    <= STABLE;
               stab_cnt <= '0;
            end
         endcase
      end
   end

   assign busy = (state == QUAL);

endmodule

// File: tb/tb_mmt_sync_edge_filter.sv
// Directed bench: three instances (default, CNT_W=2, FILT_CYCLES=1) sharing one stimulus set.
module tb_mmt_sync_edge_filter;

   logic clk = 1'b0;
   logic rstn, en, sync_in, cnt_clr;

   logic       a_filt, a_rise, a_fall, a_busy;
   logic [7:0] a_cnt;
   logic       b_filt, b_rise, b_fall, b_busy;
   logic [1:0] b_cnt;
   logic       c_filt, c_rise, c_fall, c_busy;
   logic [7:0] c_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mmt_sync_edge_filter #(.FILT_CYCLES(4), .CNT_W(8), .RST_VAL(1'b0)) dut_a (
      .clk(clk), .rstn(rstn), .en(en), .sync_in(sync_in), .cnt_clr(cnt_clr),
      .filt_q(a_filt), .rise_pls(a_rise), .fall_pls(a_fall), .evt_cnt(a_cnt), .busy(a_busy));

   mmt_sync_edge_filter #(.FILT_CYCLES(4), .CNT_W(2), .RST_VAL(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .en(en), .sync_in(sync_in), .cnt_clr(cnt_clr),
      .filt_q(b_filt), .rise_pls(b_rise), .fall_pls(b_fall), .evt_cnt(b_cnt), .busy(b_busy));

   mmt_sync_edge_filter #(.FILT_CYCLES(1), .CNT_W(8), .RST_VAL(1'b0)) dut_c (
      .clk(clk), .rstn(rstn), .en(en), .sync_in(sync_in), .cnt_clr(cnt_clr),
      .filt_q(c_filt), .rise_pls(c_rise), .fall_pls(c_fall), .evt_cnt(c_cnt), .busy(c_busy));

   // Advance one edge and settle; outputs then reflect that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; en = 1'b1; sync_in = 1'b0; cnt_clr = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b1; sync_in = 1'b1; cnt_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({a_filt, a_rise, a_fall, a_busy, a_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state cyc%0d: filt=%b rise=%b fall=%b busy=%b cnt=%0d, want all 0",
                     i, a_filt, a_rise, a_fall, a_busy, a_cnt);
         end
      end
      rstn = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (a_filt !== (i >= 4) || a_rise !== (i == 4) || a_busy !== (i < 4)) begin
            errors++;
            $display("FAIL reset_release edge%0d: filt=%b rise=%b busy=%b, want filt=%b rise=%b busy=%b",
                     i, a_filt, a_rise, a_busy, i >= 4, i == 4, i < 4);
         end
      end
      checks++;
      if (a_cnt !== 8'd1) begin
         errors++;
         $display("FAIL reset_release_cnt: cnt=%0d, want 1", a_cnt);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      sync_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (a_busy !== 1'b1 || a_filt !== 1'b0) begin
            errors++;
            $display("FAIL glitch_qual cyc%0d: busy=%b filt=%b, want busy=1 filt=0", i, a_busy, a_filt);
         end
      end
      sync_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({a_filt, a_rise, a_fall, a_busy, a_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL glitch_reject cyc%0d: filt=%b rise=%b fall=%b busy=%b cnt=%0d, want all 0",
                     i, a_filt, a_rise, a_fall, a_busy, a_cnt);
         end
      end
   endtask

   task automatic test_edges();
      int rises = 0;
      int falls = 0;
      do_reset();
      sync_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         rises += int'(a_rise);
         falls += int'(a_fall);
         checks++;
         if (a_filt !== (i >= 4) || a_rise !== (i == 4) || a_fall !== 1'b0) begin
            errors++;
            $display("FAIL edges_rise cyc%0d: filt=%b rise=%b fall=%b, want filt=%b rise=%b fall=0",
                     i, a_filt, a_rise, a_fall, i >= 4, i == 4);
         end
      end
      sync_in = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         rises += int'(a_rise);
         falls += int'(a_fall);
         checks++;
         if (a_filt !== (i < 4) || a_fall !== (i == 4) || a_rise !== 1'b0) begin
            errors++;
            $display("FAIL edges_fall cyc%0d: filt=%b rise=%b fall=%b, want filt=%b rise=0 fall=%b",
                     i, a_filt, a_rise, a_fall, i < 4, i == 4);
         end
      end
      checks++;
      if (rises != 1 || falls != 1 || a_cnt !== 8'd2) begin
         errors++;
         $display("FAIL edges_totals: rises=%0d falls=%0d cnt=%0d, want 1 1 2", rises, falls, a_cnt);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt;
      do_reset();
      for (int f = 1; f <= 5; f++) begin
         sync_in = ~sync_in;
         for (int i = 0; i < 4; i++) step();
         exp_cnt = (f > 3) ? 2'd3 : 2'(f);
         checks++;
         if (b_filt !== sync_in || b_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_flip%0d: filt=%b cnt=%0d, want filt=%b cnt=%0d",
                     f, b_filt, b_cnt, sync_in, exp_cnt);
         end
      end
      sync_in = ~sync_in;
      for (int i = 0; i < 3; i++) step();
      cnt_clr = 1'b1;
      step();
      checks++;
      if (b_cnt !== 2'd1 || b_filt !== sync_in || a_cnt !== 8'd1) begin
         errors++;
         $display("FAIL sat_clr_with_flip: b_cnt=%0d b_filt=%b a_cnt=%0d, want 1 %b 1",
                  b_cnt, b_filt, a_cnt, sync_in);
      end
      step();
      cnt_clr = 1'b0;
      checks++;
      if (b_cnt !== 2'd0) begin
         errors++;
         $display("FAIL sat_clr_alone: cnt=%0d, want 0", b_cnt);
      end
   endtask

   task automatic test_abort();
      do_reset();
      sync_in = 1'b1;
      step();
      step();
      rstn = 1'b0;
      step();
      checks++;
      if (a_busy !== 1'b0 || a_filt !== 1'b0) begin
         errors++;
         $display("FAIL abort_rst: busy=%b filt=%b, want 0 0", a_busy, a_filt);
      end
      rstn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (a_filt !== (i == 4)) begin
            errors++;
            $display("FAIL abort_rst_requal edge%0d: filt=%b, want %b", i, a_filt, i == 4);
         end
      end
      sync_in = 1'b0;
      step();
      step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cnt_clr = (i == 2);
         step();
         checks++;
         if (a_busy !== 1'b0 || a_filt !== 1'b1 || a_fall !== 1'b0) begin
            errors++;
            $display("FAIL abort_en cyc%0d: busy=%b filt=%b fall=%b, want 0 1 0", i, a_busy, a_filt, a_fall);
         end
      end
      cnt_clr = 1'b0;
      checks++;
      if (a_cnt !== 8'd0) begin
         errors++;
         $display("FAIL abort_en_clr: cnt=%0d, want 0", a_cnt);
      end
      en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (a_filt !== (i < 4) || a_fall !== (i == 4)) begin
            errors++;
            $display("FAIL abort_en_requal edge%0d: filt=%b fall=%b, want %b %b",
                     i, a_filt, a_fall, i < 4, i == 4);
         end
      end
   endtask

   task automatic test_fc1();
      logic [6:0] seq;
      logic       prev;
      logic [7:0] exp_cnt;
      seq = 7'b1001011;
      prev = 1'b0;
      exp_cnt = 8'd0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         sync_in = seq[i];
         step();
         if (sync_in != prev) exp_cnt++;
         checks++;
         if (c_filt !== sync_in || c_busy !== 1'b0 || c_rise !== (sync_in & ~prev) ||
             c_fall !== (~sync_in & prev) || c_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL fc1 cyc%0d: filt=%b busy=%b rise=%b fall=%b cnt=%0d, want %b 0 %b %b %0d",
                     i, c_filt, c_busy, c_rise, c_fall, c_cnt, sync_in,
                     sync_in & ~prev, ~sync_in & prev, exp_cnt);
         end
         prev = sync_in;
      end
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; sync_in = 1'b0; cnt_clr = 1'b0;
      test_reset();
      test_glitch();
      test_edges();
      test_saturation();
      test_abort();
      test_fc1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
